// File: rtl/xtea_word_loader_if.sv
// Word-stream handshake between an upstream source and the XTEA word loader.
interface xtea_word_loader_if;
  logic        in_valid;
  logic        in_sel;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_sel, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sel, input in_data, output in_ready);
endinterface

// File: rtl/xtea_word_loader.sv
// Assembles a 128-bit key and 128-bit data block from a 32-bit word stream,
// launches the XTEA core and waits for its completion pulse under a watchdog.
module xtea_word_loader #(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  xtea_word_loader_if.slave    word_in,
  output logic                 key_loaded,
  output logic                 start,
  output logic                 configuration,
  output logic                 aux,
  output logic [127:0]         v,
  output logic [127:0]         k,
  input  logic                 enc_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     block_count
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FULL, START, CFG, WAIT_RDY} state_t;

  state_t          state;
  logic [1:0]      key_ptr;
  logic [1:0]      data_ptr;
  logic [WD_W-1:0] wdog;
  logic [WD_W-1:0] wdog_next;
  logic            accept;
  logic            last_data;
  logic            launch;

  // Ready depends on the current word type only while waiting for the key.
  assign word_in.in_ready = !reset &&
                            ((state == IDLE) || ((state == FULL) && word_in.in_sel));
  assign accept    = word_in.in_valid && word_in.in_ready;
  assign wdog_next = wdog + WD_W'(1);

  // Decode when the launch sequence starts: last data word with key present, or key arrival while full.
  always_comb begin
    last_data = 1'b0;
    launch    = 1'b0;
    if (state == IDLE && accept && !word_in.in_sel && data_ptr == 2'd3)
      last_data = 1'b1;
    if ((last_data && key_loaded) || (state == FULL && key_loaded))
      launch = 1'b1;
  end

  // Word packing, launch sequencing, watchdog and completion counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      key_ptr       <= '0;
      data_ptr      <= '0;
      wdog          <= '0;
      key_loaded    <= 1'b0;
      start         <= 1'b0;
      configuration <= 1'b0;
      aux           <= 1'b0;
      v             <= '0;
      k             <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      block_count   <= '0;
    end else begin
      start         <= 1'b0;
      configuration <= 1'b0;
      aux           <= 1'b0;

      if (accept) begin
        if (word_in.in_sel) begin
          k[{key_ptr, 5'b0} +: 32] <= word_in.in_data;
          key_ptr                  <= key_ptr + 2'd1;
          if (key_ptr == 2'd3)
            key_loaded <= 1'b1;
        end else begin
          v[{data_ptr, 5'b0} +: 32] <= word_in.in_data;
          data_ptr                  <= data_ptr + 2'd1;
        end
      end

      if (launch) begin
        state       <= START;
        start       <= 1'b1;
        busy        <= 1'b1;
        wdog        <= '0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (last_data)
              state <= FULL;
          end
          FULL: ;
          START: begin
            configuration <= 1'b1;
            aux           <= 1'b1;
            state         <= CFG;
          end
          // Watchdog also counts the CFG cycle, so expiry lands WDOG_CYCLES cycles after CFG.
          CFG: begin
            wdog  <= wdog_next;
            state <= WAIT_RDY;
          end
          WAIT_RDY: begin
            if (enc_ready) begin
              block_count <= block_count + CNT_W'(1);
              busy        <= 1'b0;
              state       <= IDLE;
            end else if (wdog_next == WD_W'(WDOG_CYCLES)) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              wdog <= wdog_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
